// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - arbitrates the external memory bus between IF and MEM requesters
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [3:0]        mem_sel,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic [3:0]        bus_sel,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  output logic              bus_stall_request
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IF, S_BUSY_MEM, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_owner_mem;
  logic                r_flush;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [3:0]          r_bus_sel;
  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic                r_bus_err;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_mem_rdata;
  logic                w_busy;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_capture;

  assign w_busy    = (r_state == S_BUSY_IF) || (r_state == S_BUSY_MEM);
  // bus_ack in the last allowed cycle takes precedence over the abort
  assign w_timeout = w_busy && !bus_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_capture = bus_ack ? bus_rdata : '0;

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (mem_req)     w_next = S_BUSY_MEM;
        else if (if_req) w_next = S_BUSY_IF;
      end
      S_BUSY_IF, S_BUSY_MEM: begin
        if (bus_ack || w_timeout) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      r_cnt       <= '0;
      r_owner_mem <= 1'b0;
      r_flush     <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_err   <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_req) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_sel   <= mem_sel;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_wdata;
            r_owner_mem <= 1'b1;
          end else if (if_req) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'hF;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_owner_mem <= 1'b0;
          end
        end
        S_BUSY_IF, S_BUSY_MEM: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_state == S_BUSY_IF && if_flush) r_flush <= 1'b1;
          if (bus_ack || w_timeout) begin
            r_bus_req <= 1'b0;
            r_bus_err <= w_timeout;
            if (r_state == S_BUSY_IF)  r_if_rdata  <= w_capture;
            else if (!r_bus_we)        r_mem_rdata <= w_capture;
          end
        end
        default: begin
          r_cnt     <= '0;
          r_flush   <= 1'b0;
          r_bus_err <= 1'b0;
        end
      endcase
    end
  end

  // a flush arriving in the completion cycle itself must still hide the ack
  assign if_ack    = (r_state == S_DONE) && !r_owner_mem && !r_flush && !if_flush;
  assign mem_ack   = (r_state == S_DONE) && r_owner_mem;
  assign if_rdata  = r_if_rdata;
  assign mem_rdata = r_mem_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_sel   = r_bus_sel;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;
  assign bus_err   = r_bus_err;
  assign bus_stall_request = !cpu_rst && ((if_req && !if_ack) || (mem_req && !mem_ack));

endmodule
